// File: rtl/counter_segments_driver.sv
// Counts rising edges of a debounced switch and shows the 8-bit count
// as two hex digits on a pair of 7-segment displays.
//
// Ports:
//   i_Clk              system clock, all state on its rising edge
//   i_Reset            synchronous active-high reset
//   i_debouncedSignal  debounced switch level, synchronous to i_Clk
//   segLED_1A..1G      display 1 (left, high nibble) segment pins
//   segLED_2A..2G      display 2 (right, low nibble) segment pins
//
// ACTIVE_LOW=1 drives a lit segment as 0; ACTIVE_LOW=0 drives it as 1.
module counter_segments_driver #(
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_debouncedSignal,
    output logic segLED_1A,
    output logic segLED_1B,
    output logic segLED_1C,
    output logic segLED_1D,
    output logic segLED_1E,
    output logic segLED_1F,
    output logic segLED_1G,
    output logic segLED_2A,
    output logic segLED_2B,
    output logic segLED_2C,
    output logic segLED_2D,
    output logic segLED_2E,
    output logic segLED_2F,
    output logic segLED_2G
);

    // XOR mask turning "1 = lit" segment bits into pin levels.
    localparam logic [6:0] PinMask  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [6:0] ZeroPins = 7'b1111110 ^ PinMask;

    logic       r_Prev;
    logic [7:0] r_Count;
    logic [6:0] r_Seg1;
    logic [6:0] r_Seg2;

    logic       rise;
    logic [6:0] nextSeg1;
    logic [6:0] nextSeg2;

    // Segment bits ordered A..G, MSB = A, 1 = lit.
    function automatic logic [6:0] decodeHex(input logic [3:0] nibble);
        logic [6:0] lit;
        lit = 7'b0000000;
        unique case (nibble)
            4'h0: lit = 7'b1111110;
            4'h1: lit = 7'b0110000;
            4'h2: lit = 7'b1101101;
            4'h3: lit = 7'b1111001;
            4'h4: lit = 7'b0110011;
            4'h5: lit = 7'b1011011;
            4'h6: lit = 7'b1011111;
            4'h7: lit = 7'b1110000;
            4'h8: lit = 7'b1111111;
            4'h9: lit = 7'b1111011;
            4'hA: lit = 7'b1110111;
            4'hB: lit = 7'b0011111;
            4'hC: lit = 7'b1001110;
            4'hD: lit = 7'b0111101;
            4'hE: lit = 7'b1001111;
            4'hF: lit = 7'b1000111;
        endcase
        return lit;
    endfunction

    assign rise = i_debouncedSignal & ~r_Prev;

    // Segments are decoded from the registered count, so the display
    // trails the count by one clock and never sees the raw input.
    always_comb begin
        nextSeg1 = decodeHex(r_Count[7:4]) ^ PinMask;
        nextSeg2 = decodeHex(r_Count[3:0]) ^ PinMask;
    end

    // Prev is loaded from the input even during reset, so a switch held
    // high across reset release does not register as a new press.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Prev  <= i_debouncedSignal;
            r_Count <= 8'h00;
            r_Seg1  <= ZeroPins;
            r_Seg2  <= ZeroPins;
        end else begin
            r_Prev <= i_debouncedSignal;
            if (rise) begin
                r_Count <= r_Count + 8'd1;
            end
            r_Seg1 <= nextSeg1;
            r_Seg2 <= nextSeg2;
        end
    end

    assign {segLED_1A, segLED_1B, segLED_1C, segLED_1D,
            segLED_1E, segLED_1F, segLED_1G} = r_Seg1;
    assign {segLED_2A, segLED_2B, segLED_2C, segLED_2D,
            segLED_2E, segLED_2F, segLED_2G} = r_Seg2;

endmodule

// File: tb/tb_counter_segments_driver.sv
// Directed bench for counter_segments_driver.
// Expected segment pins are hand-written constants (ACTIVE_LOW=1).
module tb_counter_segments_driver;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sig = 1'b0;
    logic s1A, s1B, s1C, s1D, s1E, s1F, s1G;
    logic s2A, s2B, s2C, s2D, s2E, s2F, s2G;

    int passed = 0;
    int total  = 0;

    counter_segments_driver #(.ACTIVE_LOW(1)) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_debouncedSignal(sig),
        .segLED_1A(s1A), .segLED_1B(s1B), .segLED_1C(s1C),
        .segLED_1D(s1D), .segLED_1E(s1E), .segLED_1F(s1F),
        .segLED_1G(s1G),
        .segLED_2A(s2A), .segLED_2B(s2B), .segLED_2C(s2C),
        .segLED_2D(s2D), .segLED_2E(s2E), .segLED_2F(s2F),
        .segLED_2G(s2G)
    );

    always #5 clk = ~clk;

    // Pin patterns, A..G, 0 = lit.
    localparam logic [6:0] P0 = 7'b0000001;
    localparam logic [6:0] P1 = 7'b1001111;
    localparam logic [6:0] P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110;
    localparam logic [6:0] P4 = 7'b1001100;
    localparam logic [6:0] P5 = 7'b0100100;
    localparam logic [6:0] P6 = 7'b0100000;
    localparam logic [6:0] P7 = 7'b0001111;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0000100;
    localparam logic [6:0] PA = 7'b0001000;
    localparam logic [6:0] PB = 7'b1100000;
    localparam logic [6:0] PC = 7'b0110001;
    localparam logic [6:0] PD = 7'b1000010;
    localparam logic [6:0] PE = 7'b0110000;
    localparam logic [6:0] PF = 7'b0111000;

    typedef struct {
        string      name;
        int         pulses;
        logic [6:0] exp1;
        logic [6:0] exp2;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name,
                         input logic [6:0] e1,
                         input logic [6:0] e2);
        logic [6:0] a1;
        logic [6:0] a2;
        a1 = {s1A, s1B, s1C, s1D, s1E, s1F, s1G};
        a2 = {s2A, s2B, s2C, s2D, s2E, s2F, s2G};
        total++;
        if (a1 === e1 && a2 === e2) begin
            passed++;
        end else begin
            $display("FAIL %s: got d1=%b d2=%b want d1=%b d2=%b",
                     name, a1, a2, e1, e2);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            sig = 1'b1;
            tick();
            sig = 1'b0;
            tick();
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"cnt01", 1,   P0, P1};
        vecs[1]  = '{"cnt10", 15,  P1, P0};
        vecs[2]  = '{"cnt1A", 10,  P1, PA};
        vecs[3]  = '{"cnt37", 29,  P3, P7};
        vecs[4]  = '{"cntCE", 151, PC, PE};
        vecs[5]  = '{"cntFF", 49,  PF, PF};
        vecs[6]  = '{"wrap00", 1,  P0, P0};
        vecs[7]  = '{"cnt2B", 43,  P2, PB};
        vecs[8]  = '{"cnt94", 105, P9, P4};
        vecs[9]  = '{"cntE6", 82,  PE, P6};
        vecs[10] = '{"cntF5", 15,  PF, P5};
        vecs[11] = '{"cnt08", 19,  P0, P8};
        vecs[12] = '{"cnt0D", 5,   P0, PD};

        sig = 1'b0;
        doReset();
        check("reset", P0, P0);
        tick();
        check("idle", P0, P0);

        // Latency: count moves at edge N, pins at edge N+1.
        sig = 1'b1;
        tick();
        check("lat_n", P0, P0);
        sig = 1'b0;
        tick();
        check("lat_n1", P0, P1);
        doReset();
        check("reset2", P0, P0);

        for (int i = 0; i < 13; i++) begin
            pulses(vecs[i].pulses);
            check(vecs[i].name, vecs[i].exp1, vecs[i].exp2);
        end

        // Full wrap from zero.
        doReset();
        pulses(255);
        check("p255", PF, PF);
        pulses(1);
        check("p256", P0, P0);

        // Long hold counts once.
        doReset();
        sig = 1'b1;
        repeat (50) tick();
        check("hold", P0, P1);
        sig = 1'b0;
        repeat (3) tick();
        check("holdlow", P0, P1);
        pulses(1);
        check("rise2", P0, P2);

        // Reset while input high at 0x37.
        doReset();
        pulses(54);
        sig = 1'b1;
        tick();
        check("pre37", P3, P6);
        rst = 1'b1;
        tick();
        check("rst37", P0, P0);
        rst = 1'b0;
        repeat (5) tick();
        check("relhigh", P0, P0);
        sig = 1'b0;
        tick();
        pulses(1);
        check("after", P0, P1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
